// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32 subset core: sequences fetch, decode,
// execute, memory and writeback steps and counts retired instructions.
module multicycle_control #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       Opcode,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             AdrSrc,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOperation,
    output logic [1:0]       ResultSrc,
    output logic             Halted,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] InstRetired
);

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_BEQ      = 4'd8,
        S_TRAP     = 4'd9
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire_c;
    logic             pc_write_c, ir_write_c, mem_read_c, mem_write_c, reg_write_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and per-state control decode; strobes are gated by reset below.
    always_comb begin
        state_d      = state_q;
        retire_c     = 1'b0;
        pc_write_c   = 1'b0;
        ir_write_c   = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        reg_write_c  = 1'b0;
        AdrSrc       = 1'b0;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b00;
        ALUOperation = 2'b00;
        ResultSrc    = 2'b00;
        Halted       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_c = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                ir_write_c = MemReady;
                pc_write_c = MemReady;
                if (MemReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                if (Opcode == OP_RTYPE)                             state_d = S_EXECR;
                else if (Opcode == OP_LOAD || Opcode == OP_STORE)   state_d = S_MEMADR;
                else if (Opcode == OP_BRANCH)                       state_d = S_BEQ;
                else                                                state_d = S_TRAP;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (Opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc     = 1'b1;
                mem_read_c = 1'b1;
                if (MemReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                reg_write_c = 1'b1;
                retire_c    = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                mem_write_c = 1'b1;
                if (MemReady) begin
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_EXECR: begin
                ALUSrcA      = 2'b10;
                ALUOperation = 2'b10;
                state_d      = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                retire_c    = 1'b1;
                state_d     = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA      = 2'b10;
                ALUOperation = 2'b01;
                pc_write_c   = Zero;
                retire_c     = 1'b1;
                state_d      = S_FETCH;
            end
            S_TRAP: begin
                Halted = 1'b1;
            end
            default: state_d = S_TRAP;
        endcase
    end

    assign cnt_d       = retire_c ? cnt_q + CNT_W'(1) : cnt_q;
    assign PCWrite     = pc_write_c  & ~reset;
    assign IRWrite     = ir_write_c  & ~reset;
    assign MemRead     = mem_read_c  & ~reset;
    assign MemWrite    = mem_write_c & ~reset;
    assign RegWrite    = reg_write_c & ~reset;
    assign State       = state_q;
    assign InstRetired = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: an instruction-level model expands each
// fetched instruction into its expected step sequence and predicts every output.
module tb_multicycle_control;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [6:0]    Opcode;
    logic          Zero;
    logic          MemReady;
    logic          PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite, Halted;
    logic [1:0]    ALUSrcA, ALUSrcB, ALUOperation, ResultSrc;
    logic [3:0]    State;
    logic [CW-1:0] InstRetired;

    multicycle_control #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .MemRead(MemRead),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOperation(ALUOperation), .ResultSrc(ResultSrc), .Halted(Halted),
        .State(State), .InstRetired(InstRetired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw, irw, adr, mrd, mwr, rgw, halt;
        logic [1:0] sa, sb, aop, rs;
    } ctl_t;

    int n_total = 0;
    int n_bad   = 0;

    // Model: current step, remaining steps of this instruction, its opcode, retire count.
    int       cur;
    int       steps[$];
    logic [6:0] cur_op;
    int       cnt;
    int       trap_cycles;
    int       rst_left;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic ctl_t expect_ctl(input int st, input logic mr, input logic z);
        ctl_t c = '0;
        case (st)
            0: begin c.mrd = 1; c.sb = 2; c.rs = 2; c.irw = mr; c.pcw = mr; end
            1: begin c.sa = 1; c.sb = 1; end
            2: begin c.sa = 2; c.sb = 1; end
            3: begin c.adr = 1; c.mrd = 1; end
            4: begin c.rs = 1; c.rgw = 1; end
            5: begin c.adr = 1; c.mwr = 1; end
            6: begin c.sa = 2; c.aop = 2; end
            7: begin c.rgw = 1; end
            8: begin c.sa = 2; c.aop = 1; c.pcw = z; end
            9: begin c.halt = 1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Pick the next instruction and the steps that follow its FETCH.
    task automatic new_instr();
        int k = $urandom_range(0, 39);
        cur = 0;
        if (k < 10)      begin cur_op = 7'b0110011; steps = '{1, 6, 7}; end
        else if (k < 19) begin cur_op = 7'b0000011; steps = '{1, 2, 3, 4}; end
        else if (k < 28) begin cur_op = 7'b0100011; steps = '{1, 2, 5}; end
        else if (k < 38) begin cur_op = 7'b1100011; steps = '{1, 8}; end
        else begin
            do cur_op = 7'($urandom);
            while (cur_op == 7'b0110011 || cur_op == 7'b0000011 ||
                   cur_op == 7'b0100011 || cur_op == 7'b1100011);
            steps = '{1, 9};
        end
    endtask

    task automatic check_cycle();
        ctl_t e = expect_ctl(cur, MemReady, Zero);
        if (reset) begin
            check_eq("rst_pcwrite",  32'(PCWrite),  32'd0);
            check_eq("rst_irwrite",  32'(IRWrite),  32'd0);
            check_eq("rst_memread",  32'(MemRead),  32'd0);
            check_eq("rst_memwrite", 32'(MemWrite), 32'd0);
            check_eq("rst_regwrite", 32'(RegWrite), 32'd0);
        end else begin
            check_eq("state",        32'(State),        32'(cur));
            check_eq("instretired",  32'(InstRetired),  32'(cnt % (1 << CW)));
            check_eq("pcwrite",      32'(PCWrite),      32'(e.pcw));
            check_eq("irwrite",      32'(IRWrite),      32'(e.irw));
            check_eq("adrsrc",       32'(AdrSrc),       32'(e.adr));
            check_eq("memread",      32'(MemRead),      32'(e.mrd));
            check_eq("memwrite",     32'(MemWrite),     32'(e.mwr));
            check_eq("regwrite",     32'(RegWrite),     32'(e.rgw));
            check_eq("halted",       32'(Halted),       32'(e.halt));
            check_eq("alusrca",      32'(ALUSrcA),      32'(e.sa));
            check_eq("alusrcb",      32'(ALUSrcB),      32'(e.sb));
            check_eq("aluoperation", 32'(ALUOperation), 32'(e.aop));
            check_eq("resultsrc",    32'(ResultSrc),    32'(e.rs));
        end
    endtask

    // Model update for the coming rising edge.
    task automatic advance();
        if (reset) begin
            cnt = 0;
            trap_cycles = 0;
            new_instr();
        end else if (cur == 9) begin
            trap_cycles++;
        end else if ((cur == 0 || cur == 3 || cur == 5) && !MemReady) begin
            // memory step waits
        end else if (steps.size() == 0) begin
            cnt++;
            new_instr();
        end else begin
            cur = steps.pop_front();
        end
    endtask

    initial begin
        reset = 1'b1; MemReady = 1'b1; Zero = 1'b0; Opcode = 7'd0;
        cnt = 0; trap_cycles = 0; rst_left = 2;
        new_instr();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (rst_left == 0 && ((cur == 9 && trap_cycles >= 20) || $urandom_range(0, 249) == 0))
                rst_left = int'($urandom_range(1, 2));
            reset    = (rst_left > 0);
            if (rst_left > 0) rst_left--;
            MemReady = ($urandom_range(0, 9) < 7);
            Zero     = 1'($urandom_range(0, 1));
            // IR content only matters where the FSM decodes it.
            Opcode   = (cur == 1 || cur == 2) ? cur_op : 7'($urandom);
            #1;
            check_cycle();
            advance();
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle main control FSM for the RV32 subset core. It sequences the shared ALU, instruction/data memory port, register file and PC through fetch, decode, execute, memory and writeback steps. It drives the 2-bit `ALUOperation` code that the ALU control decoder expands with Funct3/Funct7 (00 add, 01 sub, 10 funct-decoded). A simple ready handshake on the memory port and a retired-instruction counter complete the block.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `Opcode`, input, 7: `IR[6:0]` from the instruction register.
- `Zero`, input, 1: ALU zero flag, combinational from the current ALU operation.
- `MemReady`, input, 1: memory completes the current read or write this cycle.
- `PCWrite`, output, 1: PC load strobe.
- `IRWrite`, output, 1: instruction register load strobe.
- `AdrSrc`, output, 1: memory address select; 0 = PC, 1 = ALUOut.
- `MemRead`, output, 1: memory read request.
- `MemWrite`, output, 1: memory write request.
- `RegWrite`, output, 1: register file write strobe.
- `ALUSrcA`, output, 2: ALU A operand select; 00 = PC, 01 = OldPC, 10 = rs1 latch.
- `ALUSrcB`, output, 2: ALU B operand select; 00 = rs2 latch, 01 = immediate, 10 = constant 4.
- `ALUOperation`, output, 2: code passed to the ALU control decoder.
- `ResultSrc`, output, 2: result select; 00 = ALUOut, 01 = memory data, 10 = ALU result.
- `Halted`, output, 1: set in TRAP state.
- `State`, output, 4: current state encoding, for debug.
- `InstRetired`, output, CNT_W: count of completed instructions.

## Operation
- Outputs are decoded from the registered state (Moore). The exceptions are PCWrite in BEQ and the memory strobes gated by MemReady.
- Unlisted outputs in each state are 0.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, ALUWB 7, BEQ 8, TRAP 9. Encodings 10–15 go to TRAP.
- FETCH: AdrSrc=0, MemRead=1, ALUSrcA=00, ALUSrcB=10, ALUOperation=00, ResultSrc=10. IRWrite=PCWrite=MemReady. Stay in FETCH while !MemReady, else go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOperation=00 (branch target into ALUOut). Next state by Opcode:
  - 0110011 → EXECR
  - 0000011 or 0100011 → MEMADR
  - 1100011 → BEQ
  - any other opcode → TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOperation=00. Go to MEMREAD for opcode 0000011, else MEMWRITE.
- MEMREAD: AdrSrc=1, MemRead=1. Wait for MemReady, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then go to FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1. Wait for MemReady, then go to FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOperation=10, then go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then go to FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOperation=01, ResultSrc=00, PCWrite=Zero, then go to FETCH.
- TRAP: Halted=1, all strobes 0. Stays in TRAP until reset.
- InstRetired increments by 1 on each transition into FETCH from MEMWB, ALUWB, BEQ, or MEMWRITE with MemReady. It wraps from all-ones to 0. TRAP does not count.
- Opcode is sampled only in DECODE and MEMADR. IR is stable there because IRWrite is 0 outside FETCH.

## Timing
- Reset (edge with reset=1): State=FETCH, InstRetired=0, Halted=0.
- While reset=1, PCWrite, IRWrite, MemRead, MemWrite and RegWrite are forced to 0 regardless of state.
- Reset asserted mid-instruction aborts it. There is no writeback and no count, and FETCH starts the cycle after reset deasserts.
- Zero-wait latency in cycles, FETCH to next FETCH: R-type 4, lw 5, sw 4, beq 3. Each cycle MemReady is low in FETCH, MEMREAD or MEMWRITE adds one cycle.
- A memory request stays asserted with constant AdrSrc until the cycle MemReady=1. The transfer completes in that cycle.
- MemReady is ignored in states that do not request memory.
- PCWrite in BEQ follows Zero combinationally in the same cycle.

## Test plan
- Reset: hold reset 2 cycles in MEMWRITE with MemReady=1 → MemWrite=0 during reset; after release State=0, InstRetired=0, Halted=0.
- R-type add (Opcode 0110011), MemReady tied 1 → states 0,1,6,7,0; ALUOperation=10 in EXECR; one RegWrite pulse; InstRetired=1 after 4 cycles.
- lw with MemReady low 3 cycles in MEMREAD → states 0,1,2,3,3,3,3,4,0; MemRead and AdrSrc=1 held for 4 cycles; RegWrite with ResultSrc=01; 8 cycles total.
- beq twice, Zero=1 then Zero=0 → PCWrite asserted in BEQ only the first time; ALUOperation=01; InstRetired=2 after 6 cycles.
- Opcode 1111111 → TRAP at cycle 3 with Halted=1; no strobes for 20 cycles; InstRetired unchanged; reset returns State to 0.
- Counter wrap with CNT_W=4: retire 17 R-type instructions → InstRetired reads 15 then 0 then 1.
